completion_tracker: RTL and testbench

- Return path for the 4-wide dependency checker. Accepts instructions released by the checker (its ins1..4_out strobes with the matching destination and op), holds them in an in-flight pool, and counts down a per-op execution latency.
- Drives the checker's writeback inputs (ins_back_k_vld/des) when the latency expires, and the retire strobes (ins_final_k_vld) one cycle later.
- Applies register-mask flushes to in-flight entries.

---
 rtl/completion_tracker_if.sv | 45 ++++
 rtl/completion_tracker.sv | 131 +++++++++++++
 tb/tb_completion_tracker.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/completion_tracker_if.sv
// Issue, flush, writeback and retire signals between the dependency checker
// (master) and the completion tracker (slave).
interface completion_tracker_if #(
    parameter int DEPTH = 8,
    parameter int REG_W = 4,
    parameter int OP_W  = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic              flush_en;
    logic [15:0]       flush_reg;
    logic              iss_1_vld, iss_2_vld, iss_3_vld, iss_4_vld;
    logic [REG_W-1:0]  iss_1_des, iss_2_des, iss_3_des, iss_4_des;
    logic [OP_W-1:0]   iss_1_op,  iss_2_op,  iss_3_op,  iss_4_op;
    logic              iss_rdy;
    logic              ins_back_1_vld, ins_back_2_vld, ins_back_3_vld, ins_back_4_vld;
    logic [REG_W-1:0]  ins_back_1_des, ins_back_2_des, ins_back_3_des, ins_back_4_des;
    logic              ins_final_1_vld, ins_final_2_vld, ins_final_3_vld, ins_final_4_vld;
    logic [OCC_W-1:0]  occupancy;
    logic              err_overflow;

    modport master (
        output flush_en, flush_reg,
        output iss_1_vld, iss_2_vld, iss_3_vld, iss_4_vld,
        output iss_1_des, iss_2_des, iss_3_des, iss_4_des,
        output iss_1_op,  iss_2_op,  iss_3_op,  iss_4_op,
        input  iss_rdy,
        input  ins_back_1_vld, ins_back_2_vld, ins_back_3_vld, ins_back_4_vld,
        input  ins_back_1_des, ins_back_2_des, ins_back_3_des, ins_back_4_des,
        input  ins_final_1_vld, ins_final_2_vld, ins_final_3_vld, ins_final_4_vld,
        input  occupancy, err_overflow
    );

    modport slave (
        input  flush_en, flush_reg,
        input  iss_1_vld, iss_2_vld, iss_3_vld, iss_4_vld,
        input  iss_1_des, iss_2_des, iss_3_des, iss_4_des,
        input  iss_1_op,  iss_2_op,  iss_3_op,  iss_4_op,
        output iss_rdy,
        output ins_back_1_vld, ins_back_2_vld, ins_back_3_vld, ins_back_4_vld,
        output ins_back_1_des, ins_back_2_des, ins_back_3_des, ins_back_4_des,
        output ins_final_1_vld, ins_final_2_vld, ins_final_3_vld, ins_final_4_vld,
        output occupancy, err_overflow
    );
endinterface

// File: rtl/completion_tracker.sv
// In-flight pool for released instructions: counts down per-op latency, then
// drives writeback strobes to the checker and retire strobes one cycle later.
module completion_tracker #(
    parameter int DEPTH = 8,
    parameter int REG_W = 4,
    parameter int OP_W  = 4
) (
    input logic clk,
    input logic rst,
    completion_tracker_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]             valid, on_bus;
    logic [DEPTH-1:0][REG_W-1:0]  des;
    logic [DEPTH-1:0][1:0]        cnt;
    logic                         iss_rdy, err_overflow;
    logic [OCC_W-1:0]             occupancy;
    logic [3:0]                   back_vld, final_vld;
    logic [3:0][REG_W-1:0]        back_des;

    logic [3:0]                   iss_vld;
    logic [3:0][REG_W-1:0]        iss_des;
    logic [3:0][OP_W-1:0]         iss_op;

    logic [DEPTH-1:0]             n_valid, n_sel, taken;
    logic [DEPTH-1:0][REG_W-1:0]  n_des;
    logic [DEPTH-1:0][1:0]        n_cnt;
    logic [3:0]                   n_back_vld;
    logic [3:0][REG_W-1:0]        n_back_des;
    logic [OCC_W-1:0]             n_occ;
    logic [2:0]                   n_ports;
    logic                         placed;

    assign iss_vld = {bus.iss_4_vld, bus.iss_3_vld, bus.iss_2_vld, bus.iss_1_vld};
    assign iss_des = {bus.iss_4_des, bus.iss_3_des, bus.iss_2_des, bus.iss_1_des};
    assign iss_op  = {bus.iss_4_op,  bus.iss_3_op,  bus.iss_2_op,  bus.iss_1_op};

    always_comb begin
        n_valid    = valid;
        n_des      = des;
        n_cnt      = cnt;
        taken      = '0;
        placed     = 1'b0;
        n_sel      = '0;
        n_back_vld = '0;
        n_back_des = '0;
        n_ports    = 3'd0;
        n_occ      = '0;

        // Entries on the writeback bus this cycle leave the pool at this edge.
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                if (on_bus[i])
                    n_valid[i] = 1'b0;
                else if (cnt[i] != 2'd0)
                    n_cnt[i] = cnt[i] - 2'd1;
                if (bus.flush_en && bus.flush_reg[des[i]])
                    n_valid[i] = 1'b0;
            end
        end

        // Only entries free before this edge are reused, so new issues never see the flush.
        for (int k = 0; k < 4; k++) begin
            placed = 1'b0;
            if (iss_vld[k] && iss_rdy) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!placed && !valid[i] && !taken[i]) begin
                        placed     = 1'b1;
                        taken[i]   = 1'b1;
                        n_valid[i] = 1'b1;
                        n_des[i]   = iss_des[k];
                        n_cnt[i]   = iss_op[k][OP_W-1:OP_W-2];
                    end
                end
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (n_valid[i] && n_cnt[i] == 2'd0 && n_ports < 3'd4) begin
                n_sel[i]                 = 1'b1;
                n_back_vld[n_ports[1:0]] = 1'b1;
                n_back_des[n_ports[1:0]] = n_des[i];
                n_ports                  = n_ports + 3'd1;
            end
            n_occ = n_occ + OCC_W'(n_valid[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid        <= '0;
            on_bus       <= '0;
            des          <= '0;
            cnt          <= '0;
            iss_rdy      <= 1'b0;
            err_overflow <= 1'b0;
            occupancy    <= '0;
            back_vld     <= '0;
            back_des     <= '0;
            final_vld    <= '0;
        end else begin
            valid        <= n_valid;
            on_bus       <= n_sel;
            des          <= n_des;
            cnt          <= n_cnt;
            iss_rdy      <= (n_occ <= OCC_W'(DEPTH - 4));
            err_overflow <= err_overflow | ((|iss_vld) & ~iss_rdy);
            occupancy    <= n_occ;
            back_vld     <= n_back_vld;
            back_des     <= n_back_des;
            final_vld    <= back_vld;
        end
    end

    assign bus.iss_rdy         = iss_rdy;
    assign bus.occupancy       = occupancy;
    assign bus.err_overflow    = err_overflow;
    assign bus.ins_back_1_vld  = back_vld[0];
    assign bus.ins_back_2_vld  = back_vld[1];
    assign bus.ins_back_3_vld  = back_vld[2];
    assign bus.ins_back_4_vld  = back_vld[3];
    assign bus.ins_back_1_des  = back_des[0];
    assign bus.ins_back_2_des  = back_des[1];
    assign bus.ins_back_3_des  = back_des[2];
    assign bus.ins_back_4_des  = back_des[3];
    assign bus.ins_final_1_vld = final_vld[0];
    assign bus.ins_final_2_vld = final_vld[1];
    assign bus.ins_final_3_vld = final_vld[2];
    assign bus.ins_final_4_vld = final_vld[3];
endmodule

// File: tb/tb_completion_tracker.sv
// Bench for completion_tracker: directed scenarios plus random traffic, compared
// every cycle against a due-time pool model.
module tb_completion_tracker;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    completion_tracker_if #(.DEPTH(DEPTH), .REG_W(4), .OP_W(4)) bus ();
    completion_tracker #(.DEPTH(DEPTH), .REG_W(4), .OP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic             d_rst;
    logic [3:0]       d_vld;
    logic [3:0][3:0]  d_des;
    logic [3:0][3:0]  d_op;
    logic             d_flush_en;
    logic [15:0]      d_flush_reg;

    assign rst           = d_rst;
    assign bus.flush_en  = d_flush_en;
    assign bus.flush_reg = d_flush_reg;
    assign bus.iss_1_vld = d_vld[0];
    assign bus.iss_2_vld = d_vld[1];
    assign bus.iss_3_vld = d_vld[2];
    assign bus.iss_4_vld = d_vld[3];
    assign bus.iss_1_des = d_des[0];
    assign bus.iss_2_des = d_des[1];
    assign bus.iss_3_des = d_des[2];
    assign bus.iss_4_des = d_des[3];
    assign bus.iss_1_op  = d_op[0];
    assign bus.iss_2_op  = d_op[1];
    assign bus.iss_3_op  = d_op[2];
    assign bus.iss_4_op  = d_op[3];

    logic [3:0]  o_back_vld, o_final_vld;
    logic [15:0] o_back_des;
    assign o_back_vld  = {bus.ins_back_4_vld, bus.ins_back_3_vld, bus.ins_back_2_vld, bus.ins_back_1_vld};
    assign o_final_vld = {bus.ins_final_4_vld, bus.ins_final_3_vld, bus.ins_final_2_vld, bus.ins_final_1_vld};
    assign o_back_des  = {bus.ins_back_4_des, bus.ins_back_3_des, bus.ins_back_2_des, bus.ins_back_1_des};

    // Reference pool: each entry remembers the absolute cycle at which it becomes due.
    logic [DEPTH-1:0] m_valid, m_bus;
    logic [3:0]       m_des [DEPTH];
    int               m_due [DEPTH];
    logic [3:0]       m_back_vld, m_final_vld;
    logic [3:0][3:0]  m_back_des;
    int               m_occ;
    logic             m_rdy, m_err;
    int               cyc;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [DEPTH-1:0] used;
        logic [2:0]       port;
        if (!d_rst) begin
            m_valid = '0; m_bus = '0; m_back_vld = '0; m_back_des = '0;
            m_final_vld = '0; m_occ = 0; m_rdy = 1'b0; m_err = 1'b0;
        end else begin
            used = m_valid;
            m_valid = m_valid & ~m_bus;
            if (d_flush_en)
                for (int i = 0; i < DEPTH; i++)
                    if (m_valid[i] && d_flush_reg[m_des[i]]) m_valid[i] = 1'b0;
            if (d_vld != 4'd0 && !m_rdy) m_err = 1'b1;
            if (m_rdy)
                for (int k = 0; k < 4; k++)
                    if (d_vld[k])
                        for (int i = 0; i < DEPTH; i++)
                            if (!used[i]) begin
                                used[i] = 1'b1;
                                m_valid[i] = 1'b1;
                                m_des[i] = d_des[k];
                                m_due[i] = cyc + int'(d_op[k][3:2]);
                                break;
                            end
            m_final_vld = m_back_vld;
            m_back_vld = '0; m_back_des = '0; m_bus = '0; port = 3'd0;
            for (int i = 0; i < DEPTH; i++)
                if (m_valid[i] && m_due[i] <= cyc && port < 3'd4) begin
                    m_bus[i] = 1'b1;
                    m_back_vld[port[1:0]] = 1'b1;
                    m_back_des[port[1:0]] = m_des[i];
                    port = port + 3'd1;
                end
            m_occ = 0;
            for (int i = 0; i < DEPTH; i++) m_occ += int'(m_valid[i]);
            m_rdy = (DEPTH - m_occ) >= 4;
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_val("back_vld",  32'(o_back_vld),       32'(m_back_vld));
        check_val("back_des",  32'(o_back_des),       32'(m_back_des));
        check_val("final_vld", 32'(o_final_vld),      32'(m_final_vld));
        check_val("occupancy", 32'(bus.occupancy),    32'(m_occ));
        check_val("iss_rdy",   32'(bus.iss_rdy),      32'(m_rdy));
        check_val("err_ovf",   32'(bus.err_overflow), 32'(m_err));
    endtask

    task automatic idle();
        d_vld = '0; d_flush_en = 1'b0; d_flush_reg = '0;
    endtask

    task automatic slot(input int k, input logic [3:0] des, input logic [3:0] op);
        d_vld[k] = 1'b1; d_des[k] = des; d_op[k] = op;
    endtask

    initial begin
        cyc = 0; m_valid = '0; m_bus = '0; m_back_vld = '0; m_back_des = '0;
        m_final_vld = '0; m_occ = 0; m_rdy = 1'b0; m_err = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin m_des[i] = '0; m_due[i] = 0; end
        d_rst = 1'b0; d_des = '0; d_op = '0;
        idle();

        // reset, then a single LAT=1 issue
        step(); step();
        check_val("rst_rdy", 32'(bus.iss_rdy), 32'd0);
        check_val("rst_occ", 32'(bus.occupancy), 32'd0);
        d_rst = 1'b1;
        step();
        check_val("rdy_rise", 32'(bus.iss_rdy), 32'd1);
        slot(0, 4'd3, 4'h0);
        step();
        check_val("s1_back", 32'({o_back_vld, o_back_des[3:0]}), 32'h13);
        check_val("s1_occ1", 32'(bus.occupancy), 32'd1);
        idle();
        step();
        check_val("s1_final", 32'({o_final_vld, o_back_vld}), 32'h10);
        check_val("s1_occ0", 32'(bus.occupancy), 32'd0);

        // four latencies in one cycle retire in reverse slot order
        slot(0, 4'd1, 4'hC); slot(1, 4'd2, 4'h8); slot(2, 4'd3, 4'h4); slot(3, 4'd4, 4'h0);
        step();
        idle();
        for (int j = 0; j < 4; j++) begin
            if (j > 0) step();
            check_val("s2_order", 32'({o_back_vld, o_back_des}), 32'({4'b0001, 12'h000, 4'(4 - j)}));
        end
        step(); step();

        // fill the pool, then overflow
        for (int k = 0; k < 4; k++) slot(k, 4'(k), 4'hC);
        step();
        for (int k = 0; k < 4; k++) slot(k, 4'(k + 4), 4'hC);
        step();
        check_val("s3_rdy0", 32'(bus.iss_rdy), 32'd0);
        check_val("s3_occ8", 32'(bus.occupancy), 32'd8);
        for (int k = 0; k < 4; k++) slot(k, 4'(k + 8), 4'h0);
        step();
        check_val("s3_err", 32'(bus.err_overflow), 32'd1);
        check_val("s3_occ", 32'(bus.occupancy), 32'd8);
        idle();
        step();
        check_val("s3_wb_a", 32'({o_back_vld, o_back_des}), 32'hF3210);
        step();
        check_val("s3_wb_b", 32'({o_back_vld, o_back_des}), 32'hF7654);
        step(); step();
        check_val("s3_drain", 32'(bus.occupancy), 32'd0);

        // flush an in-flight entry before it completes
        slot(0, 4'd5, 4'hC);
        step();
        idle();
        step();
        d_flush_en = 1'b1; d_flush_reg = 16'h0020;
        step();
        idle();
        check_val("s4_occ", 32'(bus.occupancy), 32'd0);
        for (int j = 0; j < 4; j++) begin
            step();
            check_val("s4_noback", 32'(o_back_vld), 32'd0);
        end

        // six entries due together
        for (int k = 0; k < 4; k++) slot(k, 4'(k + 8), 4'h4);
        step();
        idle();
        slot(0, 4'd12, 4'h0); slot(1, 4'd13, 4'h1);
        step();
        check_val("s5_first", 32'({o_back_vld, o_back_des}), 32'hFBA98);
        idle();
        step();
        check_val("s5_rest", 32'({o_back_vld, o_back_des}), 32'h300DC);
        step(); step();

        // reset with entries in flight
        for (int k = 0; k < 3; k++) slot(k, 4'(k + 1), 4'hC);
        step();
        idle();
        d_rst = 1'b0;
        step();
        check_val("s6_zero", 32'({o_back_vld, o_final_vld, bus.occupancy, bus.iss_rdy, bus.err_overflow}), 32'd0);
        d_rst = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            check_val("s6_stale", 32'({o_back_vld, o_final_vld}), 32'd0);
        end

        // random traffic
        for (int j = 0; j < 600; j++) begin
            d_rst       = ($urandom_range(0, 79) != 0);
            d_flush_en  = ($urandom_range(0, 7) == 0);
            d_flush_reg = 16'($urandom & $urandom & $urandom);
            for (int k = 0; k < 4; k++) begin
                d_vld[k] = (m_rdy || $urandom_range(0, 15) == 0) && ($urandom_range(0, 1) == 1);
                d_des[k] = 4'($urandom);
                d_op[k]  = 4'($urandom);
            end
            step();
        end
        idle();
        for (int j = 0; j < 8; j++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
